// File: rtl/jk_pkg.sv
// jk_pkg
// Shared definitions for the JK register bank.
//   mode_e     : bank operating mode (JK / D / T / up-down counter)
//   jk_code_e  : per-flip-flop function selected by {j,k}
//   jk_next()  : next-state of a single JK flip-flop
package jk_pkg;

  typedef enum logic [1:0] {
    MODE_JK    = 2'b00,
    MODE_D     = 2'b01,
    MODE_T     = 2'b10,
    MODE_COUNT = 2'b11
  } mode_e;

  // {j,k} read as a two-bit code
  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_CLR  = 2'b01,
    JK_SET  = 2'b10,
    JK_TOG  = 2'b11
  } jk_code_e;

  function automatic logic jk_next(input logic q, input jk_code_e code);
    logic nq;
    nq = q;
    case (code)
      JK_HOLD: nq = q;
      JK_CLR:  nq = 1'b0;
      JK_SET:  nq = 1'b1;
      JK_TOG:  nq = ~q;
      default: nq = q;
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/jk_reg_bank_if.sv
// jk_reg_bank_if
// Control and data bundle of the JK register bank.
//   en, mode, load, load_data, j, k : driven by the user of the bank
//   q, qn, changed, wrap            : driven by the bank
// master = user side, slave = the bank itself.
interface jk_reg_bank_if #(
  parameter int WIDTH = 8
);
  import jk_pkg::*;

  logic             en;
  mode_e            mode;
  logic             load;
  logic [WIDTH-1:0] load_data;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qn;
  logic [WIDTH-1:0] changed;
  logic             wrap;

  modport master (
    output en, mode, load, load_data, j, k,
    input  q, qn, changed, wrap
  );

  modport slave (
    input  en, mode, load, load_data, j, k,
    output q, qn, changed, wrap
  );

endinterface

// File: rtl/jk_cell.sv
// jk_cell
// One JK flip-flop with clock enable, parallel load and a change flag.
//   clk, reset    : clock, synchronous active-high reset (q <= RESET_BIT)
//   en            : enable for the JK update
//   load, load_bit: parallel load, wins over en
//   j, k          : JK function inputs
//   q             : flip-flop state
//   chg           : 1 when q changed on the last edge
module jk_cell
  import jk_pkg::*;
#(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic load,
  input  logic load_bit,
  input  logic j,
  input  logic k,
  output logic q,
  output logic chg
);

  logic nq;

  assign nq = jk_next(q, jk_code_e'({j, k}));

  // reset > load > en; chg is cleared on any cycle where q is held
  always_ff @(posedge clk) begin
    if (reset) begin
      q   <= RESET_BIT;
      chg <= 1'b0;
    end else if (load) begin
      q   <= load_bit;
      chg <= q ^ load_bit;
    end else if (en) begin
      q   <= nq;
      chg <= q ^ nq;
    end else begin
      chg <= 1'b0;
    end
  end

endmodule

// File: rtl/jk_reg_bank.sv
// jk_reg_bank
// WIDTH-bit bank of JK flip-flops usable as JK, D or T register, or as a
// synchronous up/down counter.
//   clk, reset : clock, synchronous active-high reset (q <= RESET_VALUE)
//   bus        : jk_reg_bank_if slave port
//                en/mode/load/load_data/j/k in, q/qn/changed/wrap out
// In COUNT mode j[0] means up and k[0] means down; both or neither hold.
module jk_reg_bank
  import jk_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic         clk,
  input  logic         reset,
  jk_reg_bank_if.slave bus
);

  logic [WIDTH-1:0] q_int;
  logic [WIDTH-1:0] chg_int;
  logic             up;
  logic             down;
  logic             wrap_r;

  assign up   = bus.j[0] & ~bus.k[0];
  assign down = bus.k[0] & ~bus.j[0];

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    logic lower_ones;
    logic lower_zeros;
    logic tog;
    logic cj;
    logic ck;

    // A counter bit toggles when every lower bit is 1 (carry in) for up,
    // or every lower bit is 0 (borrow in) for down. Bit 0 always toggles.
    if (gi == 0) begin : g_lsb
      assign lower_ones  = 1'b1;
      assign lower_zeros = 1'b1;
    end else begin : g_upper
      assign lower_ones  = &q_int[gi-1:0];
      assign lower_zeros = ~|q_int[gi-1:0];
    end

    assign tog = (up & lower_ones) | (down & lower_zeros);

    // D is JK with k = ~j; T and COUNT are JK with j = k = toggle
    always_comb begin
      cj = 1'b0;
      ck = 1'b0;
      case (bus.mode)
        MODE_JK: begin
          cj = bus.j[gi];
          ck = bus.k[gi];
        end
        MODE_D: begin
          cj = bus.j[gi];
          ck = ~bus.j[gi];
        end
        MODE_T: begin
          cj = bus.j[gi];
          ck = bus.j[gi];
        end
        MODE_COUNT: begin
          cj = tog;
          ck = tog;
        end
        default: begin
          cj = 1'b0;
          ck = 1'b0;
        end
      endcase
    end

    jk_cell #(
      .RESET_BIT (RESET_VALUE[gi])
    ) u_cell (
      .clk      (clk),
      .reset    (reset),
      .en       (bus.en),
      .load     (bus.load),
      .load_bit (bus.load_data[gi]),
      .j        (cj),
      .k        (ck),
      .q        (q_int[gi]),
      .chg      (chg_int[gi])
    );
  end

  // wrap pulses only on an enabled counting edge that rolls over
  always_ff @(posedge clk) begin
    if (reset) begin
      wrap_r <= 1'b0;
    end else if (bus.load || !bus.en) begin
      wrap_r <= 1'b0;
    end else begin
      wrap_r <= (bus.mode == MODE_COUNT) &&
                ((up && (&q_int)) || (down && !(|q_int)));
    end
  end

  assign bus.q       = q_int;
  assign bus.qn      = ~q_int;
  assign bus.changed = chg_int;
  assign bus.wrap    = wrap_r;

endmodule
